// File: rtl/taxi_xgmii_tx_lpi_ctrl.sv
// EEE low-power-idle sequencer placed ahead of a 64-bit XGMII 10GBASE-R encoder.
// Substitutes LPI/IDLE control blocks while asleep and drives the PHY TX-quiet strobe.
module taxi_xgmii_tx_lpi_ctrl #(
    parameter int TS_CYC = 20,
    parameter int TQ_CYC = 2048,
    parameter int TR_CYC = 16,
    parameter int TW_CYC = 24,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] s_xgmii_txd,
    input  logic [7:0]  s_xgmii_txc,
    input  logic        s_xgmii_tx_valid,
    output logic        s_ready,
    input  logic        lpi_req,
    output logic [63:0] m_xgmii_txd,
    output logic [7:0]  m_xgmii_txc,
    output logic        m_xgmii_tx_valid,
    output logic        tx_quiet,
    output logic        lpi_active,
    output logic        stat_drop
);

    localparam logic [63:0] IDLE_D = {8{8'h07}};
    localparam logic [63:0] LPI_D  = {8{8'h06}};

    localparam logic [CNT_W-1:0] TS_LAST = CNT_W'(TS_CYC - 1);
    localparam logic [CNT_W-1:0] TQ_LAST = CNT_W'(TQ_CYC - 1);
    localparam logic [CNT_W-1:0] TR_LAST = CNT_W'(TR_CYC - 1);
    localparam logic [CNT_W-1:0] TW_LAST = CNT_W'(TW_CYC - 1);

    typedef enum logic [2:0] {
        ST_ACTIVE,
        ST_SLEEP,
        ST_QUIET,
        ST_REFRESH,
        ST_WAKE
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_lim;
    logic [63:0]      txd_reg;
    logic [7:0]       txc_reg;
    logic             valid_reg;
    logic             quiet_reg;
    logic             active_reg;
    logic             drop_reg;
    logic             ready_reg;

    // A block counts as "quiet" when every lane is the same IDLE or LPI control character
    logic [7:0] lane_idle;
    logic [7:0] lane_lpi;
    logic       quiet_blk;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_idle[gi] = (s_xgmii_txd[8*gi +: 8] == 8'h07);
            assign lane_lpi[gi]  = (s_xgmii_txd[8*gi +: 8] == 8'h06);
        end
    endgenerate

    assign quiet_blk = (s_xgmii_txc == 8'hff) && ((&lane_idle) || (&lane_lpi));

    // Timer limit and successor for each timed phase
    always_comb begin
        cnt_lim    = '0;
        state_next = ST_ACTIVE;
        case (state_reg)
            ST_SLEEP:   begin cnt_lim = TS_LAST; state_next = ST_QUIET;   end
            ST_QUIET:   begin cnt_lim = TQ_LAST; state_next = ST_REFRESH; end
            ST_REFRESH: begin cnt_lim = TR_LAST; state_next = ST_QUIET;   end
            ST_WAKE:    begin cnt_lim = TW_LAST; state_next = ST_ACTIVE;  end
            default:    begin cnt_lim = '0;      state_next = ST_ACTIVE;  end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_ACTIVE;
            cnt_reg    <= '0;
            txd_reg    <= IDLE_D;
            txc_reg    <= 8'hff;
            valid_reg  <= 1'b0;
            quiet_reg  <= 1'b0;
            active_reg <= 1'b0;
            drop_reg   <= 1'b0;
            ready_reg  <= 1'b1;
        end else begin
            valid_reg <= s_xgmii_tx_valid;
            drop_reg  <= 1'b0;
            if (state_reg == ST_ACTIVE) begin
                if (s_xgmii_tx_valid && lpi_req && quiet_blk) begin
                    // This LPI block is the first of the sleep period
                    txd_reg    <= LPI_D;
                    txc_reg    <= 8'hff;
                    active_reg <= 1'b1;
                    quiet_reg  <= 1'b0;
                    ready_reg  <= 1'b0;
                    if (TS_CYC == 1) begin
                        state_reg <= ST_QUIET;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= ST_SLEEP;
                        cnt_reg   <= CNT_W'(1);
                    end
                end else begin
                    txd_reg <= s_xgmii_txd;
                    txc_reg <= s_xgmii_txc;
                end
            end else if (s_xgmii_tx_valid) begin
                drop_reg <= !quiet_blk;
                txc_reg  <= 8'hff;
                if (state_reg != ST_WAKE && !lpi_req) begin
                    // Wake request wins over any timer expiring on the same block
                    state_reg  <= ST_WAKE;
                    cnt_reg    <= '0;
                    txd_reg    <= IDLE_D;
                    quiet_reg  <= 1'b0;
                    active_reg <= 1'b0;
                end else begin
                    txd_reg    <= (state_reg == ST_WAKE) ? IDLE_D : LPI_D;
                    quiet_reg  <= (state_reg == ST_QUIET);
                    active_reg <= (state_reg != ST_WAKE);
                    if (cnt_reg == cnt_lim) begin
                        state_reg <= state_next;
                        cnt_reg   <= '0;
                        ready_reg <= (state_next == ST_ACTIVE);
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign m_xgmii_txd      = txd_reg;
    assign m_xgmii_txc      = txc_reg;
    assign m_xgmii_tx_valid = valid_reg;
    assign tx_quiet         = quiet_reg;
    assign lpi_active       = active_reg;
    assign stat_drop        = drop_reg;
    assign s_ready          = ready_reg;

endmodule
